debounced_button_pio: RTL and testbench
=======================================

# debounced_button_pio

Parametrised memory-mapped input port for push-buttons and switches. It generalises the 4-bit edge-capturing button port to WIDTH channels and adds:
- a per-channel synchroniser and debounce filter,
- rising, falling or both-edge capture selected per channel,
- a raw-input readback register.

It sits on the processor's Avalon-MM slave fabric and drives one level-sensitive interrupt line.

## Interface
- WIDTH, 4, number of input channels (1..32)
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a level change is accepted (>= 2); counter width is clog2(DEBOUNCE_CYCLES)

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; a write happens when chipselect=1 and write_n=0
- writedata  in  WIDTH  write data
- in_port  in  WIDTH  asynchronous button/switch inputs
- readdata  out  WIDTH  registered read data
- irq  out  1  interrupt, OR of (edge_capture & irq_mask)

## Operation
- Register map (address : name : access):
  - 0 : data : RO, debounced levels
  - 2 : irq_mask : RW
  - 3 : edge_capture : write-1-to-clear
  - 4 : rise_en : RW
  - 5 : fall_en : RW
  - 6 : raw : RO, synchronised in_port before debounce
  - 1 and 7 : unmapped; read 0, writes ignored
- Read mux: readdata loads the selected register on every clk edge, regardless of chipselect.
- Synchroniser: two flops per channel, sync1 <= in_port and sync2 <= sync1. raw = sync2.
- Debounce, per channel i, with state stable[i] and cnt[i]:
  - sync2[i] == stable[i]: cnt[i] <= 0.
  - Otherwise, cnt[i] == DEBOUNCE_CYCLES-1: stable[i] <= sync2[i] and cnt[i] <= 0.
  - Otherwise: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles at sync2 never reaches stable.
- Edge detect: stable_d <= stable every cycle.
  - rise = stable & ~stable_d & rise_en
  - fall = ~stable & stable_d & fall_en
  - edge = rise | fall
- Edge capture, per bit:
  - edge[i]=1: set to 1. An edge wins over a same-cycle write-1-clear, so no event is lost.
  - Else a write to address 3 with writedata[i]=1: clear to 0.
  - Else: hold.
- irq is combinational from the edge_capture and irq_mask registers.
- Reset values, all synchronous to clk:
  - readdata, irq_mask, edge_capture, fall_en, sync1, sync2, stable, stable_d, cnt: 0
  - rise_en: all ones (legacy rising-edge behaviour)
  - irq: 0
- An input held high through reset produces a rising-edge capture once its debounce completes after reset release.
- Reset asserted mid-debounce discards partial counts.

## Timing
- in_port change to data register: with the first sampling edge counted as edge 1, stable updates on edge DEBOUNCE_CYCLES+2. The change is readable in readdata on the following edge.
- stable change to edge_capture set: 1 cycle. irq rises in the same cycle as the capture bit.
- Read latency: readdata is valid 1 cycle after address is presented. No wait states.
- Write effect: register updates on the edge where the write is sampled. A new irq_mask takes effect on irq in the next cycle.
- Changing rise_en or fall_en never retroactively sets or clears edge_capture.

## Test plan
- Reset release: WIDTH=4, DEBOUNCE_CYCLES=4, in_port=0. All reads return 0 except address 4, which returns 4'hF. irq=0.
- Press with debounce: hold in_port=4'b0001 from edge 1.
  - data reads 1 after stable updates on edge 6.
  - edge_capture=4'b0001 on edge 7.
  - With irq_mask=1, irq=1 from edge 7 until address 3 is written with 1.
- Glitch reject: pulse in_port[1] high for 3 cycles, then low. data, raw-based debounce and edge_capture bit 1 all stay 0. raw shows the pulse 2 cycles delayed.
- Falling/both edges: rise_en=0 and fall_en=4'b0100; press then release ch2. Capture bit 2 sets only on release. With both enables set, it sets on both press and release.
- Clear versus edge collision: arrange a write of 4'hF to address 3 on the same cycle that edge[3]=1. Afterwards edge_capture[3]=1 and the other bits are 0.
- Mid-debounce reset: assert reset_n=0 for 1 cycle while cnt=2, then keep in_port high. stable sets on edge DEBOUNCE_CYCLES+2 counted from reset release, not earlier.

Source files
------------

// File: rtl/debounced_button_pio.sv
// debounced_button_pio: WIDTH-channel push-button/switch input port on an
// Avalon-MM slave. Each channel is synchronised, debounced and edge-detected;
// selected edges latch into edge_capture, which drives a level interrupt.
module debounced_button_pio #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] readdata,
   output logic             irq
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] stable_prev_q;
   logic [WIDTH-1:0] irq_mask_q,     irq_mask_d;
   logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
   logic [WIDTH-1:0] rise_en_q,      rise_en_d;
   logic [WIDTH-1:0] fall_en_q,      fall_en_d;
   logic [WIDTH-1:0] readdata_q,     readdata_d;
   logic [WIDTH-1:0] edge_v;
   logic [WIDTH-1:0] clr_v;
   logic             wr_en;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_q, cnt_d;
         logic             stable_nxt;

         // Debounce: accept the synchronised level only after it has disagreed
         // with the current stable level for DEBOUNCE_CYCLES consecutive cycles.
         always_comb begin
            cnt_d      = cnt_q;
            stable_nxt = stable_q[gi];
            if (sync2_q[gi] == stable_q[gi]) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               stable_nxt = sync2_q[gi];
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         // Debounce counter; reset discards any partial count.
         always_ff @(posedge clk) begin
            if (!reset_n) cnt_q <= '0;
            else          cnt_q <= cnt_d;
         end

         assign stable_d[gi] = stable_nxt;
      end
   endgenerate

   // Register writes, edge detection, edge capture and the read mux.
   always_comb begin
      wr_en       = chipselect & ~write_n;
      irq_mask_d  = irq_mask_q;
      rise_en_d   = rise_en_q;
      fall_en_d   = fall_en_q;
      if (wr_en) begin
         case (address)
            3'd2:    irq_mask_d = writedata;
            3'd4:    rise_en_d  = writedata;
            3'd5:    fall_en_d  = writedata;
            default: ;
         endcase
      end

      edge_v = (stable_q & ~stable_prev_q & rise_en_q) |
               (~stable_q & stable_prev_q & fall_en_q);
      clr_v  = (wr_en && address == 3'd3) ? writedata : '0;
      // A same-cycle edge overrides the write-1-clear so no event is lost.
      edge_capture_d = edge_v | (edge_capture_q & ~clr_v);

      case (address)
         3'd0:    readdata_d = stable_q;
         3'd2:    readdata_d = irq_mask_q;
         3'd3:    readdata_d = edge_capture_q;
         3'd4:    readdata_d = rise_en_q;
         3'd5:    readdata_d = fall_en_q;
         3'd6:    readdata_d = sync2_q;
         default: readdata_d = '0;
      endcase
   end

   // All port state; rise_en resets to all ones for legacy rising-edge capture.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_q        <= '0;
         sync2_q        <= '0;
         stable_q       <= '0;
         stable_prev_q  <= '0;
         irq_mask_q     <= '0;
         edge_capture_q <= '0;
         rise_en_q      <= '1;
         fall_en_q      <= '0;
         readdata_q     <= '0;
      end else begin
         sync1_q        <= in_port;
         sync2_q        <= sync1_q;
         stable_q       <= stable_d;
         stable_prev_q  <= stable_q;
         irq_mask_q     <= irq_mask_d;
         edge_capture_q <= edge_capture_d;
         rise_en_q      <= rise_en_d;
         fall_en_q      <= fall_en_d;
         readdata_q     <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_debounced_button_pio.sv
// Testbench for debounced_button_pio: directed scenarios plus random traffic,
// checked by a scoreboard fed from a cycle-level behavioural model.
module tb_debounced_button_pio;

   localparam int W = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset_n;
   logic [2:0]   address;
   logic         chipselect;
   logic         write_n;
   logic [W-1:0] writedata;
   logic [W-1:0] in_port;
   logic [W-1:0] readdata;
   logic         irq;

   int total = 0;
   int bad   = 0;

   debounced_button_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_port),
      .readdata(readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [W-1:0] m_stable, m_prev, m_mask, m_rise, m_fall, m_cap, m_raw;
   logic [W-1:0] in_q[$];
   logic [W-1:0] obs_q[$];
   logic [W-1:0] exp_rd_q[$];
   logic         exp_irq_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock edge of the model, using the inputs the DUT samples on that edge.
   task automatic model_edge();
      logic [W-1:0] rdv, edg, nstable, clr;
      logic         all_diff;
      if (!reset_n) begin
         m_stable = '0; m_prev = '0; m_mask = '0; m_cap = '0;
         m_rise = '1; m_fall = '0; m_raw = '0;
         in_q.delete(); obs_q.delete();
         if (chipselect && write_n) exp_rd_q.push_back('0);
         exp_irq_q.push_back(1'b0);
         return;
      end
      case (address)
         3'd0:    rdv = m_stable;
         3'd2:    rdv = m_mask;
         3'd3:    rdv = m_cap;
         3'd4:    rdv = m_rise;
         3'd5:    rdv = m_fall;
         3'd6:    rdv = m_raw;
         default: rdv = '0;
      endcase
      if (chipselect && write_n) exp_rd_q.push_back(rdv);

      // A channel takes a new level when the last D observations all disagree
      // with its current level.
      obs_q.push_back(m_raw);
      if (obs_q.size() > D) void'(obs_q.pop_front());
      nstable = m_stable;
      for (int i = 0; i < W; i++) begin
         if (obs_q.size() == D) begin
            all_diff = 1'b1;
            foreach (obs_q[j]) if (obs_q[j][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) nstable[i] = ~m_stable[i];
         end
      end

      edg = '0;
      for (int i = 0; i < W; i++) begin
         if (m_stable[i] && !m_prev[i] && m_rise[i]) edg[i] = 1'b1;
         if (!m_stable[i] && m_prev[i] && m_fall[i]) edg[i] = 1'b1;
      end
      clr = (chipselect && !write_n && address == 3'd3) ? writedata : '0;
      for (int i = 0; i < W; i++) begin
         if (edg[i])      m_cap[i] = 1'b1;
         else if (clr[i]) m_cap[i] = 1'b0;
      end
      if (chipselect && !write_n) begin
         if (address == 3'd2) m_mask = writedata;
         if (address == 3'd4) m_rise = writedata;
         if (address == 3'd5) m_fall = writedata;
      end
      m_prev   = m_stable;
      m_stable = nstable;

      in_q.push_back(in_port);
      if (in_q.size() > 2) void'(in_q.pop_front());
      m_raw = (in_q.size() == 2) ? in_q[0] : '0;

      exp_irq_q.push_back(|(m_cap & m_mask));
   endtask

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic issued;
      logic [W-1:0] e;
      logic ei;
      forever begin
         @(posedge clk);
         issued = chipselect && write_n;
         #1;
         if (exp_irq_q.size() == 0) begin
            chk("irq_queue_empty", 32'd0, 32'd1);
         end else begin
            ei = exp_irq_q.pop_front();
            chk("irq", {31'd0, irq}, {31'd0, ei});
         end
         if (issued) begin
            if (exp_rd_q.size() == 0) begin
               chk("rd_queue_empty", 32'd0, 32'd1);
            end else begin
               e = exp_rd_q.pop_front();
               chk("readdata", 32'(readdata), 32'(e));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic rd(input logic [2:0] a);
      chipselect = 1'b1; write_n = 1'b1; address = a;
      cycle();
      chipselect = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      cycle();
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int hit_irq, hit_dat;
      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = '0; writedata = '0; in_port = '0;
      repeat (3) cycle();
      reset_n = 1'b1;

      // Reset state: everything reads 0 except rise_en.
      for (int a = 0; a < 8; a++) begin
         rd(3'(a));
         chk("reset_read", 32'(readdata), (a == 4) ? 32'hF : 32'h0);
      end
      chk("reset_irq", {31'd0, irq}, 32'd0);

      // Press ch0: stable on edge 6, capture and irq on edge 7.
      wr(3'd2, 4'h1);
      in_port = 4'b0001;
      hit_irq = 0; hit_dat = 0;
      for (int k = 1; k <= 20; k++) begin
         rd(3'd0);
         if (irq && hit_irq == 0) hit_irq = k;
         if (readdata[0] && hit_dat == 0) hit_dat = k;
      end
      chk("press_irq_edge", 32'(hit_irq), 32'd7);
      chk("press_data_edge", 32'(hit_dat), 32'd7);
      chk("irq_held", {31'd0, irq}, 32'd1);
      wr(3'd3, 4'h1);
      chk("irq_cleared", {31'd0, irq}, 32'd0);

      // Glitch on ch1 shorter than the debounce window.
      in_port[1] = 1'b1;
      repeat (3) rd(3'd6);
      in_port[1] = 1'b0;
      repeat (10) rd(3'd6);
      rd(3'd3);
      chk("glitch_cap", 32'(readdata[1]), 32'd0);
      rd(3'd0);
      chk("glitch_data", 32'(readdata), 32'h1);

      // Falling-only on ch2, then both edges.
      wr(3'd4, 4'h0); wr(3'd5, 4'h4);
      in_port[2] = 1'b1;
      repeat (10) rd(3'd3);
      chk("fall_only_press", 32'(readdata[2]), 32'd0);
      in_port[2] = 1'b0;
      repeat (10) rd(3'd3);
      chk("fall_only_release", 32'(readdata[2]), 32'd1);
      wr(3'd3, 4'hF); wr(3'd4, 4'h4);
      in_port[2] = 1'b1;
      repeat (10) rd(3'd3);
      chk("both_press", 32'(readdata[2]), 32'd1);
      wr(3'd3, 4'hF);
      in_port[2] = 1'b0;
      repeat (10) rd(3'd3);
      chk("both_release", 32'(readdata[2]), 32'd1);

      // Clear colliding with an edge on ch3.
      wr(3'd4, 4'hF); wr(3'd5, 4'h0); wr(3'd3, 4'hF);
      in_port = 4'b0111;
      repeat (10) cycle();
      in_port = 4'b1111;
      repeat (6) cycle();
      wr(3'd3, 4'hF);
      rd(3'd3);
      chk("collision_cap", 32'(readdata), 32'h8);

      // Reset in the middle of a debounce count.
      in_port = 4'b0000;
      repeat (10) cycle();
      in_port = 4'b0001;
      repeat (4) cycle();
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      hit_dat = 0;
      for (int k = 1; k <= 20; k++) begin
         rd(3'd0);
         if (readdata[0] && hit_dat == 0) hit_dat = k;
      end
      chk("midreset_data_edge", 32'(hit_dat), 32'd7);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 1'b0; cycle(); reset_n = 1'b1;
         end
         case ($urandom_range(0, 3))
            0:       cycle();
            1, 2:    rd(3'($urandom_range(0, 7)));
            default: wr(3'($urandom_range(0, 7)), W'($urandom));
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
